// File: rtl/countdown_timer_ctrl.sv
// Two-digit BCD countdown timer controller with load/start/pause control, clocked on the falling edge.
// Optional auto-reload on terminal count is enabled by defining COUNTDOWN_AUTO_RELOAD_EN.
module countdown_timer_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] preset,
  input  logic       start,
  input  logic       pause,
  input  logic       tick,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic       busy,
  output logic       done,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOADED = 3'd1,
    RUN    = 3'd2,
    PAUSED = 3'd3,
    DONE   = 3'd4
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] tens_q, tens_d;
  logic [3:0] ones_q, ones_d;
  logic [3:0] presetTens_q, presetTens_d;
  logic [3:0] presetOnes_q, presetOnes_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;

  logic countIsZero;
  logic countIsOne;
  logic presetIsZero;

  function automatic logic [3:0] clampDigit(input logic [3:0] digit);
    return (digit > 4'd9) ? 4'd9 : digit;
  endfunction

  assign countIsZero  = (tens_q == 4'd0) && (ones_q == 4'd0);
  assign countIsOne   = (tens_q == 4'd0) && (ones_q == 4'd1);
  assign presetIsZero = (presetTens_q == 4'd0) && (presetOnes_q == 4'd0);

  // Next-state logic; load overrides every state, then per-state handling.
  always_comb begin
    state_d      = state_q;
    tens_d       = tens_q;
    ones_d       = ones_q;
    presetTens_d = presetTens_q;
    presetOnes_d = presetOnes_q;
    done_d       = 1'b0;

    if (load) begin
      presetTens_d = clampDigit(preset[7:4]);
      presetOnes_d = clampDigit(preset[3:0]);
      tens_d       = clampDigit(preset[7:4]);
      ones_d       = clampDigit(preset[3:0]);
      state_d      = LOADED;
    end else begin
      case (state_q)
        IDLE: ;
        LOADED: begin
          if (start) begin
            if (countIsZero) begin
              state_d = DONE;
              done_d  = 1'b1;
            end else begin
              state_d = RUN;
            end
          end
        end
        RUN: begin
          if (pause) begin
            state_d = PAUSED;
          end else if (tick) begin
            if (countIsZero) begin
`ifdef COUNTDOWN_AUTO_RELOAD_EN
              // Count sat at 00 for one cycle after the terminal pulse; reload now.
              tens_d = presetTens_q;
              ones_d = presetOnes_q;
              if (presetIsZero) state_d = DONE;
`else
              state_d = DONE;
`endif
            end else if (countIsOne) begin
              tens_d = 4'd0;
              ones_d = 4'd0;
              done_d = 1'b1;
`ifndef COUNTDOWN_AUTO_RELOAD_EN
              state_d = DONE;
`endif
            end else if (ones_q == 4'd0) begin
              ones_d = 4'd9;
              tens_d = tens_q - 4'd1;
            end else begin
              ones_d = ones_q - 4'd1;
            end
          end
        end
        PAUSED: begin
          if (start && !pause) state_d = RUN;
        end
        DONE: ;
        default: state_d = IDLE;
      endcase
    end

    busy_d = (state_d == RUN) || (state_d == PAUSED);
  end

  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      tens_q       <= 4'd0;
      ones_q       <= 4'd0;
      presetTens_q <= 4'd0;
      presetOnes_q <= 4'd0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      tens_q       <= tens_d;
      ones_q       <= ones_d;
      presetTens_q <= presetTens_d;
      presetOnes_q <= presetOnes_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign tens  = tens_q;
  assign ones  = ones_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign state = state_q;

endmodule

// File: tb/tb_countdown_timer_ctrl.sv
// Directed self-checking bench for countdown_timer_ctrl; observed word is {state, tens, ones, busy, done}.
module tb_countdown_timer_ctrl;

  logic       clk;
  logic       reset;
  logic       load;
  logic [7:0] preset;
  logic       start;
  logic       pause;
  logic       tick;
  logic [3:0] tens;
  logic [3:0] ones;
  logic       busy;
  logic       done;
  logic [2:0] state;

  int errors = 0;
  int checks = 0;

  countdown_timer_ctrl dut (
    .clk    (clk),
    .reset  (reset),
    .load   (load),
    .preset (preset),
    .start  (start),
    .pause  (pause),
    .tick   (tick),
    .tens   (tens),
    .ones   (ones),
    .busy   (busy),
    .done   (done),
    .state  (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [12:0] observed();
    return {state, tens, ones, busy, done};
  endfunction

  function automatic logic [12:0] expWord(input logic [2:0] s, input int value, input logic b, input logic d);
    logic [3:0] t, o;
    t = 4'(value / 10);
    o = 4'(value % 10);
    return {s, t, o, b, d};
  endfunction

  // Inputs change and outputs are sampled 1 time unit after the active falling edge.
  task automatic nextEdge();
    @(negedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic l, input logic [7:0] p, input logic s, input logic pa, input logic t);
    load   = l;
    preset = p;
    start  = s;
    pause  = pa;
    tick   = t;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    #2;
    checks++;
    if (observed() !== expWord(3'd0, 0, 1'b0, 1'b0)) begin
      errors++;
      $display("[TB] FAIL reset_state got=%h exp=%h", observed(), expWord(3'd0, 0, 1'b0, 1'b0));
    end
    @(posedge clk);
    reset = 1'b1;
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    nextEdge();
    checks++;
    if (observed() !== expWord(3'd0, 0, 1'b0, 1'b0)) begin
      errors++;
      $display("[TB] FAIL idle_start_ignored got=%h exp=%h", observed(), expWord(3'd0, 0, 1'b0, 1'b0));
    end
  endtask

  task automatic test_basic_countdown();
    int doneCount;
    doneCount = 0;
    applyStimulus(1'b1, 8'h12, 1'b0, 1'b0, 1'b0);
    nextEdge();
    checks++;
    if (observed() !== expWord(3'd1, 12, 1'b0, 1'b0)) begin
      errors++;
      $display("[TB] FAIL basic_loaded got=%h exp=%h", observed(), expWord(3'd1, 12, 1'b0, 1'b0));
    end
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    nextEdge();
    checks++;
    if (observed() !== expWord(3'd2, 12, 1'b1, 1'b0)) begin
      errors++;
      $display("[TB] FAIL basic_start got=%h exp=%h", observed(), expWord(3'd2, 12, 1'b1, 1'b0));
    end
    start = 1'b0;
    for (int v = 11; v >= 1; v--) begin
      nextEdge();
      if (done) doneCount++;
      checks++;
      if (observed() !== expWord(3'd2, v, 1'b1, 1'b0)) begin
        errors++;
        $display("[TB] FAIL basic_count_%0d got=%h exp=%h", v, observed(), expWord(3'd2, v, 1'b1, 1'b0));
      end
    end
    nextEdge();
    if (done) doneCount++;
    checks++;
    if (observed() !== expWord(3'd4, 0, 1'b0, 1'b1)) begin
      errors++;
      $display("[TB] FAIL basic_terminal got=%h exp=%h", observed(), expWord(3'd4, 0, 1'b0, 1'b1));
    end
    start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      nextEdge();
      if (done) doneCount++;
    end
    start = 1'b0;
    checks++;
    if (observed() !== expWord(3'd4, 0, 1'b0, 1'b0)) begin
      errors++;
      $display("[TB] FAIL basic_done_hold got=%h exp=%h", observed(), expWord(3'd4, 0, 1'b0, 1'b0));
    end
    checks++;
    if (doneCount !== 1) begin
      errors++;
      $display("[TB] FAIL basic_done_pulses got=%0d exp=1", doneCount);
    end
  endtask

  task automatic test_clamp();
    applyStimulus(1'b1, 8'hAF, 1'b0, 1'b0, 1'b0);
    nextEdge();
    checks++;
    if (observed() !== expWord(3'd1, 99, 1'b0, 1'b0)) begin
      errors++;
      $display("[TB] FAIL clamp_AF got=%h exp=%h", observed(), expWord(3'd1, 99, 1'b0, 1'b0));
    end
    preset = 8'h3C;
    nextEdge();
    checks++;
    if (observed() !== expWord(3'd1, 39, 1'b0, 1'b0)) begin
      errors++;
      $display("[TB] FAIL clamp_3C got=%h exp=%h", observed(), expWord(3'd1, 39, 1'b0, 1'b0));
    end
    load = 1'b0;
  endtask

  task automatic test_pause();
    applyStimulus(1'b1, 8'h05, 1'b0, 1'b0, 1'b0);
    nextEdge();
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    nextEdge();
    start = 1'b0;
    nextEdge();
    nextEdge();
    checks++;
    if (observed() !== expWord(3'd2, 3, 1'b1, 1'b0)) begin
      errors++;
      $display("[TB] FAIL pause_reach03 got=%h exp=%h", observed(), expWord(3'd2, 3, 1'b1, 1'b0));
    end
    pause = 1'b1;
    for (int i = 0; i < 4; i++) begin
      nextEdge();
      checks++;
      if (observed() !== expWord(3'd3, 3, 1'b1, 1'b0)) begin
        errors++;
        $display("[TB] FAIL pause_hold_%0d got=%h exp=%h", i, observed(), expWord(3'd3, 3, 1'b1, 1'b0));
      end
    end
    start = 1'b1;
    nextEdge();
    checks++;
    if (observed() !== expWord(3'd3, 3, 1'b1, 1'b0)) begin
      errors++;
      $display("[TB] FAIL pause_start_and_pause got=%h exp=%h", observed(), expWord(3'd3, 3, 1'b1, 1'b0));
    end
    pause = 1'b0;
    nextEdge();
    checks++;
    if (observed() !== expWord(3'd2, 3, 1'b1, 1'b0)) begin
      errors++;
      $display("[TB] FAIL pause_resume got=%h exp=%h", observed(), expWord(3'd2, 3, 1'b1, 1'b0));
    end
    start = 1'b0;
    nextEdge();
    checks++;
    if (observed() !== expWord(3'd2, 2, 1'b1, 1'b0)) begin
      errors++;
      $display("[TB] FAIL pause_count02 got=%h exp=%h", observed(), expWord(3'd2, 2, 1'b1, 1'b0));
    end
  endtask

  task automatic test_reset_mid_run();
    applyStimulus(1'b1, 8'h47, 1'b0, 1'b0, 1'b0);
    nextEdge();
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    nextEdge();
    start = 1'b0;
    checks++;
    if (observed() !== expWord(3'd2, 47, 1'b1, 1'b0)) begin
      errors++;
      $display("[TB] FAIL midrun_at47 got=%h exp=%h", observed(), expWord(3'd2, 47, 1'b1, 1'b0));
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (observed() !== expWord(3'd0, 0, 1'b0, 1'b0)) begin
      errors++;
      $display("[TB] FAIL midrun_async_reset got=%h exp=%h", observed(), expWord(3'd0, 0, 1'b0, 1'b0));
    end
    @(posedge clk);
    reset = 1'b1;
    tick  = 1'b1;
    nextEdge();
    checks++;
    if (observed() !== expWord(3'd0, 0, 1'b0, 1'b0)) begin
      errors++;
      $display("[TB] FAIL midrun_after_release got=%h exp=%h", observed(), expWord(3'd0, 0, 1'b0, 1'b0));
    end
  endtask

  task automatic test_zero_preset();
    applyStimulus(1'b1, 8'h00, 1'b0, 1'b0, 1'b1);
    nextEdge();
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    nextEdge();
    start = 1'b0;
    checks++;
    if (observed() !== expWord(3'd4, 0, 1'b0, 1'b1)) begin
      errors++;
      $display("[TB] FAIL zero_done_pulse got=%h exp=%h", observed(), expWord(3'd4, 0, 1'b0, 1'b1));
    end
    nextEdge();
    checks++;
    if (observed() !== expWord(3'd4, 0, 1'b0, 1'b0)) begin
      errors++;
      $display("[TB] FAIL zero_done_single got=%h exp=%h", observed(), expWord(3'd4, 0, 1'b0, 1'b0));
    end
  endtask

  task automatic test_back_to_back();
    applyStimulus(1'b1, 8'h30, 1'b0, 1'b0, 1'b1);
    nextEdge();
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    nextEdge();
    start = 1'b0;
    nextEdge();
    checks++;
    if (observed() !== expWord(3'd2, 29, 1'b1, 1'b0)) begin
      errors++;
      $display("[TB] FAIL b2b_wrap29 got=%h exp=%h", observed(), expWord(3'd2, 29, 1'b1, 1'b0));
    end
    applyStimulus(1'b1, 8'h64, 1'b1, 1'b1, 1'b1);
    nextEdge();
    checks++;
    if (observed() !== expWord(3'd1, 64, 1'b0, 1'b0)) begin
      errors++;
      $display("[TB] FAIL b2b_load_priority got=%h exp=%h", observed(), expWord(3'd1, 64, 1'b0, 1'b0));
    end
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    nextEdge();
    start = 1'b0;
    nextEdge();
    checks++;
    if (observed() !== expWord(3'd2, 64, 1'b1, 1'b0)) begin
      errors++;
      $display("[TB] FAIL b2b_no_tick_hold got=%h exp=%h", observed(), expWord(3'd2, 64, 1'b1, 1'b0));
    end
  endtask

`ifdef COUNTDOWN_AUTO_RELOAD_EN
  task automatic test_auto_reload();
    applyStimulus(1'b1, 8'h02, 1'b0, 1'b0, 1'b1);
    nextEdge();
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    nextEdge();
    start = 1'b0;
    nextEdge();
    checks++;
    if (observed() !== expWord(3'd2, 1, 1'b1, 1'b0)) begin
      errors++;
      $display("[TB] FAIL auto_01 got=%h exp=%h", observed(), expWord(3'd2, 1, 1'b1, 1'b0));
    end
    nextEdge();
    checks++;
    if (observed() !== expWord(3'd2, 0, 1'b1, 1'b1)) begin
      errors++;
      $display("[TB] FAIL auto_00 got=%h exp=%h", observed(), expWord(3'd2, 0, 1'b1, 1'b1));
    end
    nextEdge();
    checks++;
    if (observed() !== expWord(3'd2, 2, 1'b1, 1'b0)) begin
      errors++;
      $display("[TB] FAIL auto_reload02 got=%h exp=%h", observed(), expWord(3'd2, 2, 1'b1, 1'b0));
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic_countdown();
    test_clamp();
    test_pause();
    test_reset_mid_run();
    test_zero_preset();
    test_back_to_back();
`ifdef COUNTDOWN_AUTO_RELOAD_EN
    test_auto_reload();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
